dmem_port_arbiter: RTL

// - Shares the single data-memory port between the pipeline MEM stage (core) and an external

---
 rtl/dmem_port_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data-memory port between the MEM stage and an external requester.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_func3,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [2:0]        ext_func3,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner_ext,
  output logic [CNT_W-1:0]  stat_core_stalls,
  output logic [CNT_W-1:0]  stat_ext_grants
);
  typedef enum logic {OWN_CORE, OWN_EXT} state_t;
  localparam int WW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  state_t state, state_n, st;
  logic [WW-1:0] wait_cnt, wait_n, wc;
  logic [LW-1:0] lock_cnt, lock_n;
  logic core_req, core_gnt, ext_rd_gnt;
  // During reset the decision logic behaves as an idle OWN_CORE with cleared counters
  always_comb begin
    core_req = core_rd | core_wr;
    st = reset ? OWN_CORE : state;
    wc = reset ? '0 : wait_cnt;
    core_gnt = 1'b0;
    ext_gnt = 1'b0;
    state_n = OWN_CORE;
    lock_n = '0;
    if (st == OWN_CORE) begin
      core_gnt = core_req && (wc < WW'(STARVE_MAX));
      ext_gnt = !core_gnt && ext_req;
      state_n = (ext_gnt && ext_lock && LOCK_MAX > 1) ? OWN_EXT : OWN_CORE;
    end else begin
      ext_gnt = ext_req;
      // the entry grant in OWN_CORE counts toward the burst, hence +2
      state_n = (ext_req && ext_lock && (32'(lock_cnt) + 32'd2 < LOCK_MAX)) ? OWN_EXT : OWN_CORE;
      lock_n = (state_n == OWN_EXT) ? lock_cnt + 1'b1 : '0;
    end
    wait_n = (ext_req && !ext_gnt) ? ((wc == WW'(STARVE_MAX)) ? wc : wc + 1'b1) : '0;
    ext_rd_gnt = ext_gnt & ~ext_we;
    core_stall = core_req & ~core_gnt;
    mem_rd = core_gnt ? core_rd : ext_rd_gnt;
    mem_wr = core_gnt ? core_wr : (ext_gnt & ext_we);
    mem_addr = ext_gnt ? ext_addr : core_addr;
    mem_wdata = ext_gnt ? ext_wdata : core_wdata;
    mem_func3 = ext_gnt ? ext_func3 : core_func3;
    core_rdata = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OWN_CORE;
      wait_cnt <= '0;
      lock_cnt <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_n;
      lock_cnt <= lock_n;
      ext_rvalid <= ext_rd_gnt;
      if (ext_rd_gnt) ext_rdata <= mem_rdata;
    end
  end
  assign owner_ext = (state == OWN_EXT);
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_core_stalls <= '0;
      stat_ext_grants <= '0;
    end else begin
      if (core_stall && !(&stat_core_stalls)) stat_core_stalls <= stat_core_stalls + 1'b1;
      if (ext_gnt && !(&stat_ext_grants)) stat_ext_grants <= stat_ext_grants + 1'b1;
    end
  end
`else
  assign stat_core_stalls = '0;
  assign stat_ext_grants = '0;
`endif
endmodule
